// File: rtl/eer_rl_pkg.sv
// Shared packet types and the default-width TX descriptor for the EER-RL node.
package eer_rl_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_TS_W   = 6;
  localparam int DEF_LVL_W  = 2;

  localparam logic [63:0] BROADCAST_ID = '1;

  typedef enum logic [2:0] {
    HEARTBEAT = 3'b000,
    INVITE    = 3'b010,
    MEMREQ    = 3'b011,
    TIMESLOT  = 3'b100,
    DATA      = 3'b101,
    INVALID   = 3'b111
  } pkt_t;

  typedef struct packed {
    logic [DEF_WORD_W-1:0] srcId;
    logic [DEF_WORD_W-1:0] energy;
    logic [DEF_WORD_W-1:0] qValue;
    logic [DEF_WORD_W-1:0] srcHops;
    logic [DEF_WORD_W-1:0] dstId;
    logic [DEF_WORD_W-1:0] chosenCh;
    logic [DEF_WORD_W-1:0] hopsFromCh;
    pkt_t                  pktType;
    logic [DEF_TS_W-1:0]   slot;
    logic [DEF_LVL_W-1:0]  level;
  } tx_desc_t;

endpackage

// File: rtl/reward_desc_fifo.sv
// Descriptor FIFO; extra pointer MSB separates full from empty. A push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module reward_desc_fifo
  import eer_rl_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type desc_t = tx_desc_t
) (
  input  logic  clk,
  input  logic  nrst,
  input  logic  push,
  input  logic  pop,
  input  desc_t pushData,
  output desc_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  desc_t mem [DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic        doPush;
  logic        doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign head   = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/reward_tx_scheduler.sv
// Reward/response stage: builds TX descriptors from RX events, local data and the
// membership-request timer, queues them and hands them to the TX path on okToSend.
module reward_tx_scheduler
  import eer_rl_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int DEPTH       = 4,
  parameter int TX_LEVELS   = 4,
  parameter int TS_W        = 6,
  parameter int MEMREQ_WAIT = 12,
  parameter int DROP_W      = 8
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         en,
  input  logic                         iHaveData,
  input  logic                         iAmDestination,
  input  logic                         okToSend,
  input  logic [WORD_W-1:0]            myNodeID,
  input  logic [WORD_W-1:0]            hopsFromSink,
  input  logic [WORD_W-1:0]            myQValue,
  input  logic [WORD_W-1:0]            myEnergy,
  input  logic                         role,
  input  logic                         low_E,
  input  logic [WORD_W-1:0]            timeslot,
  input  logic [2:0]                   fPacketType,
  input  logic [WORD_W-1:0]            fSourceID,
  input  logic [WORD_W-1:0]            fSourceHops,
  input  logic [WORD_W-1:0]            fQValue,
  input  logic [WORD_W-1:0]            fEnergyLeft,
  input  logic [WORD_W-1:0]            fHopsFromCH,
  input  logic [WORD_W-1:0]            fChosenCH,
  input  logic [WORD_W-1:0]            chosenCH,
  input  logic [WORD_W-1:0]            hopsFromCH,
  input  logic [WORD_W-1:0]            chosenHop,
  output logic [WORD_W-1:0]            rSourceID,
  output logic [WORD_W-1:0]            rEnergyLeft,
  output logic [WORD_W-1:0]            rQValue,
  output logic [WORD_W-1:0]            rSourceHops,
  output logic [WORD_W-1:0]            rDestinationID,
  output logic [WORD_W-1:0]            rChosenCH,
  output logic [WORD_W-1:0]            rHopsFromCH,
  output logic [2:0]                   rPacketType,
  output logic [TS_W-1:0]              rTimeslot,
  output logic                         tx_valid,
  output logic [$clog2(TX_LEVELS)-1:0] tx_setting,
  output logic                         reward_done,
  output logic                         q_full,
  output logic [DROP_W-1:0]            drop_count
);

  localparam int LVL_W = $clog2(TX_LEVELS);
  localparam int TW    = $clog2(MEMREQ_WAIT + 1);

  typedef struct packed {
    logic [WORD_W-1:0] srcId;
    logic [WORD_W-1:0] energy;
    logic [WORD_W-1:0] qValue;
    logic [WORD_W-1:0] srcHops;
    logic [WORD_W-1:0] dstId;
    logic [WORD_W-1:0] chosenCh;
    logic [WORD_W-1:0] hopsFromCh;
    pkt_t              pktType;
    logic [TS_W-1:0]   slot;
    logic [LVL_W-1:0]  level;
  } desc_t;

  desc_t pushDesc, headDesc, outDesc;
  logic  localReq, rxHb, rxInv, rxData, dataReq, dataBad;
  logic  enPush, enDrop, expiry, memPush, pushReq, popEff, dropFull, fifoEmpty;
  logic  timerOn;
  logic [TW-1:0]     timerCnt;
  logic [WORD_W-1:0] hopsM1;
  logic [LVL_W-1:0]  memLevel;
  logic [1:0]        dropInc;
  logic [DROP_W:0]   dropSum;
  logic              unusedRxFields;

  // An en with iHaveData is the local request; the RX fields of that cycle lose.
  assign localReq = en & iHaveData;
  assign rxHb     = en & ~iHaveData & (fPacketType == HEARTBEAT);
  assign rxInv    = en & ~iHaveData & (fPacketType == INVITE);
  assign rxData   = en & ~iHaveData & iAmDestination & (fPacketType == DATA);
  assign dataReq  = localReq | rxData;
  assign dataBad  = dataReq & (chosenHop == BROADCAST_ID[WORD_W-1:0]);
  assign enPush   = (localReq | rxHb | rxInv | rxData) & ~dataBad;
  assign enDrop   = en & ~enPush;

  // Expiry holds while blocked, so a lost arbitration is retried next cycle.
  assign expiry   = timerOn & (timerCnt == '0);
  assign memPush  = expiry & ~enPush;
  assign pushReq  = enPush | memPush;
  assign popEff   = okToSend & tx_valid;
  assign dropFull = pushReq & q_full & ~popEff;
  assign dropInc  = {1'b0, enDrop} + {1'b0, dropFull};
  assign dropSum  = {1'b0, drop_count} + (DROP_W+1)'(dropInc);

  assign hopsM1 = hopsFromCH - WORD_W'(1);

  always_comb begin
    memLevel = '0;
    if (hopsFromCH == '0)                       memLevel = '0;
    else if (hopsM1 >= WORD_W'(TX_LEVELS - 1))  memLevel = LVL_W'(TX_LEVELS - 1);
    else                                        memLevel = hopsM1[LVL_W-1:0];
  end

  always_comb begin
    pushDesc        = '0;
    pushDesc.srcId  = myNodeID;
    pushDesc.energy = myEnergy;
    pushDesc.qValue = myQValue;
    pushDesc.slot   = timeslot[TS_W-1:0];
    if (memPush) begin
      pushDesc.pktType    = MEMREQ;
      pushDesc.dstId      = chosenCH;
      pushDesc.hopsFromCh = hopsFromCH;
      pushDesc.level      = memLevel;
    end else if (dataReq) begin
      pushDesc.pktType  = DATA;
      pushDesc.dstId    = chosenHop;
      pushDesc.chosenCh = chosenCH;
      if (rxData) begin
        pushDesc.srcId  = fSourceID;
        pushDesc.energy = fEnergyLeft;
      end
    end else if (rxInv) begin
      pushDesc.pktType    = INVITE;
      pushDesc.dstId      = BROADCAST_ID[WORD_W-1:0];
      pushDesc.chosenCh   = chosenCH;
      pushDesc.hopsFromCh = hopsFromCH;
    end else begin
      pushDesc.pktType = HEARTBEAT;
      pushDesc.dstId   = BROADCAST_ID[WORD_W-1:0];
      pushDesc.srcHops = hopsFromSink;
    end
  end

  reward_desc_fifo #(.DEPTH(DEPTH), .desc_t(desc_t)) uFifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (pushReq),
    .pop     (okToSend),
    .pushData(pushDesc),
    .head    (headDesc),
    .full    (q_full),
    .empty   (fifoEmpty)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timerOn  <= 1'b0;
      timerCnt <= '0;
    end else if (rxInv && !role) begin
      timerOn  <= 1'b1;
      timerCnt <= TW'(MEMREQ_WAIT - 1);
    end else if (expiry) begin
      if (memPush) timerOn <= 1'b0;
    end else if (timerOn) begin
      timerCnt <= timerCnt - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      reward_done <= 1'b0;
      drop_count  <= '0;
    end else begin
      reward_done <= popEff;
      drop_count  <= dropSum[DROP_W] ? '1 : dropSum[DROP_W-1:0];
    end
  end

  assign tx_valid = ~fifoEmpty;

  always_comb begin
    outDesc         = '0;
    outDesc.pktType = INVALID;
    if (tx_valid) outDesc = headDesc;
  end

  assign rSourceID      = outDesc.srcId;
  assign rEnergyLeft    = outDesc.energy;
  assign rQValue        = outDesc.qValue;
  assign rSourceHops    = outDesc.srcHops;
  assign rDestinationID = outDesc.dstId;
  assign rChosenCH      = outDesc.chosenCh;
  assign rHopsFromCH    = outDesc.hopsFromCh;
  assign rPacketType    = outDesc.pktType;
  assign rTimeslot      = outDesc.slot;
  assign tx_setting     = low_E ? '0 : outDesc.level;

  assign unusedRxFields = ^{fSourceHops, fQValue, fHopsFromCH, fChosenCH, timeslot};

endmodule

// File: tb/tb_reward_tx_scheduler.sv
// Directed bench for reward_tx_scheduler with hand-computed expectations.
module tb_reward_tx_scheduler;
  import eer_rl_pkg::*;

  localparam int WORD_W      = 16;
  localparam int DEPTH       = 4;
  localparam int TX_LEVELS   = 4;
  localparam int TS_W        = 6;
  localparam int MEMREQ_WAIT = 12;
  localparam int DROP_W      = 8;

  logic clk = 1'b0;
  logic nrst, en, iHaveData, iAmDestination, okToSend, role, low_E;
  logic [WORD_W-1:0] myNodeID, hopsFromSink, myQValue, myEnergy, timeslot;
  logic [2:0]        fPacketType;
  logic [WORD_W-1:0] fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;
  logic [WORD_W-1:0] chosenCH, hopsFromCH, chosenHop;
  logic [WORD_W-1:0] rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH;
  logic [2:0]        rPacketType;
  logic [TS_W-1:0]   rTimeslot;
  logic              tx_valid, reward_done, q_full;
  logic [1:0]        tx_setting;
  logic [DROP_W-1:0] drop_count;

  int testsRun = 0;
  int testsFailed = 0;
  logic [WORD_W-1:0] expQ[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  reward_tx_scheduler #(
    .WORD_W(WORD_W), .DEPTH(DEPTH), .TX_LEVELS(TX_LEVELS), .TS_W(TS_W),
    .MEMREQ_WAIT(MEMREQ_WAIT), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .iHaveData(iHaveData), .iAmDestination(iAmDestination),
    .okToSend(okToSend), .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
    .myEnergy(myEnergy), .role(role), .low_E(low_E), .timeslot(timeslot), .fPacketType(fPacketType),
    .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fQValue(fQValue), .fEnergyLeft(fEnergyLeft),
    .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH), .chosenCH(chosenCH), .hopsFromCH(hopsFromCH),
    .chosenHop(chosenHop), .rSourceID(rSourceID), .rEnergyLeft(rEnergyLeft), .rQValue(rQValue),
    .rSourceHops(rSourceHops), .rDestinationID(rDestinationID), .rChosenCH(rChosenCH),
    .rHopsFromCH(rHopsFromCH), .rPacketType(rPacketType), .rTimeslot(rTimeslot), .tx_valid(tx_valid),
    .tx_setting(tx_setting), .reward_done(reward_done), .q_full(q_full), .drop_count(drop_count)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendEvent(input logic [2:0] ptype, input logic localData, input logic forMe);
    fPacketType    = ptype;
    iHaveData      = localData;
    iAmDestination = forMe;
    en             = 1'b1;
    tick();
    en             = 1'b0;
    iHaveData      = 1'b0;
    iAmDestination = 1'b0;
  endtask

  task automatic popHead();
    okToSend = 1'b1;
    tick();
    okToSend = 1'b0;
  endtask

  // ticks until tx_valid rises; n continues the caller's edge count
  task automatic waitValid(inout int n, input int limit);
    while (!tx_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int seen;
    nrst = 1'b0; en = 1'b0; iHaveData = 1'b0; iAmDestination = 1'b0; okToSend = 1'b0;
    role = 1'b0; low_E = 1'b0;
    myNodeID = 16'h0042; hopsFromSink = 16'd3; myQValue = 16'h3555; myEnergy = 16'h5000;
    timeslot = 16'h0047; fPacketType = 3'b000;
    fSourceID = 16'd23; fSourceHops = 16'd0; fQValue = 16'h0; fEnergyLeft = 16'h0;
    fHopsFromCH = 16'd0; fChosenCH = 16'd0;
    chosenCH = 16'd23; hopsFromCH = 16'd1; chosenHop = 16'h0017;
    #12;
    checkEq("rst_tx_valid", tx_valid, 0);
    checkEq("rst_type", rPacketType, 3'b111);
    checkEq("rst_src", rSourceID, 0);
    checkEq("rst_setting", tx_setting, 0);
    checkEq("rst_done", reward_done, 0);
    checkEq("rst_full", q_full, 0);
    checkEq("rst_drop", drop_count, 0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    // 1: heartbeat ripple and pop handshake
    sendEvent(HEARTBEAT, 1'b0, 1'b0);
    checkEq("hb_valid", tx_valid, 1);
    checkEq("hb_type", rPacketType, 3'b000);
    checkEq("hb_hops", rSourceHops, 3);
    checkEq("hb_dest", rDestinationID, 16'hFFFF);
    checkEq("hb_q", rQValue, 16'h3555);
    checkEq("hb_src", rSourceID, 16'h0042);
    checkEq("hb_slot", rTimeslot, 6'h07);
    popHead();
    checkEq("hb_done", reward_done, 1);
    checkEq("hb_empty", tx_valid, 0);
    tick();
    checkEq("hb_done_pulse", reward_done, 0);
    popHead();
    checkEq("idle_pop_done", reward_done, 0);

    // 2: invite, then MEMREQ after MEMREQ_WAIT cycles
    sendEvent(INVITE, 1'b0, 1'b0);
    n = 0;
    checkEq("inv_type", rPacketType, 3'b010);
    checkEq("inv_ch", rChosenCH, 23);
    checkEq("inv_hops", rHopsFromCH, 1);
    checkEq("inv_dest", rDestinationID, 16'hFFFF);
    popHead(); n++;
    waitValid(n, 40);
    checkEq("memreq_delay", n, MEMREQ_WAIT);
    checkEq("memreq_type", rPacketType, 3'b011);
    checkEq("memreq_dest", rDestinationID, 23);
    checkEq("memreq_level", tx_setting, 0);
    popHead();

    // second invite 5 cycles after the first pushes MEMREQ back by 5
    sendEvent(INVITE, 1'b0, 1'b0);
    n = 0;
    popHead(); n++;
    tick(); tick(); tick(); n += 3;
    sendEvent(INVITE, 1'b0, 1'b0); n++;
    popHead(); n++;
    waitValid(n, 60);
    checkEq("memreq_restart", n, MEMREQ_WAIT + 5);
    checkEq("memreq2_type", rPacketType, 3'b011);
    popHead();

    // MEMREQ power level from hopsFromCH=3, and low_E override
    hopsFromCH = 16'd3;
    sendEvent(INVITE, 1'b0, 1'b0);
    n = 0;
    popHead(); n++;
    waitValid(n, 40);
    checkEq("lvl_type", rPacketType, 3'b011);
    checkEq("lvl_hops3", tx_setting, 2);
    low_E = 1'b1;
    #1;
    checkEq("lvl_lowE", tx_setting, 0);
    low_E = 1'b0;
    popHead();
    hopsFromCH = 16'd1;

    // 3: local data, then local data with no next hop
    sendEvent(DATA, 1'b1, 1'b0);
    checkEq("ld_type", rPacketType, 3'b101);
    checkEq("ld_dest", rDestinationID, 16'h0017);
    checkEq("ld_src", rSourceID, 16'h0042);
    checkEq("ld_ch", rChosenCH, 23);
    popHead();
    chosenHop = 16'hFFFF;
    sendEvent(DATA, 1'b1, 1'b0);
    checkEq("ld_nohop_valid", tx_valid, 0);
    checkEq("ld_nohop_drop", drop_count, 1);
    chosenHop = 16'h0017;

    // 4: forwarded data keeps originator identity
    fSourceID = 16'd35; fEnergyLeft = 16'h7000;
    sendEvent(DATA, 1'b0, 1'b1);
    checkEq("fw_type", rPacketType, 3'b101);
    checkEq("fw_src", rSourceID, 35);
    checkEq("fw_energy", rEnergyLeft, 16'h7000);
    checkEq("fw_dest", rDestinationID, 16'h0017);
    popHead();

    // 5: overflow, push+pop while full, FIFO order
    for (int i = 0; i < DEPTH + 2; i++) begin
      hopsFromSink = WORD_W'(10 + i);
      if (i < DEPTH) expQ.push_back(WORD_W'(10 + i));
      sendEvent(HEARTBEAT, 1'b0, 1'b0);
    end
    checkEq("ovf_full", q_full, 1);
    checkEq("ovf_drop", drop_count, 3);
    checkEq("ovf_head", rSourceHops, expQ[0]);
    hopsFromSink = 16'd20;
    fPacketType = HEARTBEAT;
    en = 1'b1; okToSend = 1'b1;
    tick();
    en = 1'b0; okToSend = 1'b0;
    void'(expQ.pop_front());
    expQ.push_back(16'd20);
    checkEq("pp_full", q_full, 1);
    checkEq("pp_drop", drop_count, 3);
    for (int i = 0; i < DEPTH; i++) begin
      checkEq($sformatf("drain%0d_valid", i), tx_valid, 1);
      checkEq($sformatf("drain%0d_order", i), rSourceHops, expQ.pop_front());
      popHead();
    end
    checkEq("drain_empty", tx_valid, 0);
    checkEq("drain_notfull", q_full, 0);

    // 6: reset mid-operation clears the queue and the timer
    sendEvent(HEARTBEAT, 1'b0, 1'b0);
    sendEvent(HEARTBEAT, 1'b0, 1'b0);
    sendEvent(INVITE, 1'b0, 1'b0);
    checkEq("pre_rst_valid", tx_valid, 1);
    tick(); tick();
    #2;
    nrst = 1'b0;
    #1;
    checkEq("mid_rst_valid", tx_valid, 0);
    checkEq("mid_rst_type", rPacketType, 3'b111);
    checkEq("mid_rst_src", rSourceID, 0);
    checkEq("mid_rst_drop", drop_count, 0);
    checkEq("mid_rst_full", q_full, 0);
    checkEq("mid_rst_setting", tx_setting, 0);
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * MEMREQ_WAIT; i++) begin
      tick();
      if (tx_valid) seen++;
    end
    checkEq("post_rst_no_memreq", seen, 0);

    // report
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
